// File: rtl/password_candidate_gen.sv
// password_candidate_gen
//   Producer side of the cracker datapath. Enumerates every NUM_CHARS-character
//   candidate over the 36-symbol alphabet a..z,0..9 whose leading character index
//   lies in [FROM_IDX, TO_IDX]. Candidates go out over a valid/ready handshake.
//   The block reports completion (exhausted) or abort through done/exhausted.
//
//   Ports:
//     clk, rst      clock (rising edge) and async active-high reset
//     start         pulse; begins enumeration from IDLE or DONE
//     abort         stop request; honoured only while running
//     cand_valid    candidate on cand_data is valid
//     cand_ready    consumer accepts the candidate this cycle
//     cand_data     ASCII candidate, leftmost char in the MSBs
//     done          high in DONE
//     exhausted     high with done when the whole range was consumed
//     cand_count    (CAND_COUNT_EN only) accepted candidates since start
//
//   Optional feature: define CAND_COUNT_EN to add the cand_count output.

// Alphabet index -> ASCII for a single character position.
module pcg_char_map (
    input  logic [5:0] idx,
    output logic [7:0] ch
);
    always_comb begin
        if (idx < 6'd26) ch = 8'h61 + {2'b00, idx};
        else             ch = 8'h30 + ({2'b00, idx} - 8'd26);
    end
endmodule

module password_candidate_gen #(
    parameter int NUM_CHARS = 4,
    parameter int FROM_IDX  = 0,
    parameter int TO_IDX    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic                   cand_valid,
    input  logic                   cand_ready,
    output logic [8*NUM_CHARS-1:0] cand_data,
    output logic                   done,
`ifdef CAND_COUNT_EN
    output logic [31:0]            cand_count,
`endif
    output logic                   exhausted
);
    localparam logic [5:0] FROM_D = 6'(FROM_IDX);
    localparam logic [5:0] TO_D   = 6'(TO_IDX);
    localparam logic [5:0] MAX_D  = 6'd35;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state, state_n;

    // Digit 0 is the rightmost (fastest) character, digit NUM_CHARS-1 the leading one.
    logic [NUM_CHARS-1:0][5:0] digits, digits_n;
    logic [NUM_CHARS-1:0][7:0] chars_n;
    logic exh_n, load, adv, take, is_last, carry;

    assign cand_valid = (state == S_RUN);
    assign done       = (state == S_DONE);

    // Final candidate is {TO_IDX, 35, ..., 35}.
    always_comb begin
        is_last = (digits[NUM_CHARS-1] == TO_D);
        for (int i = 0; i < NUM_CHARS-1; i++)
            if (digits[i] != MAX_D) is_last = 1'b0;
    end

    always_comb begin
        state_n = state;
        exh_n   = exhausted;
        load    = 1'b0;
        adv     = 1'b0;
        take    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_RUN;
                    exh_n   = 1'b0;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                // Abort wins over a same-cycle accept: nothing is consumed.
                if (abort) begin
                    state_n = S_DONE;
                    exh_n   = 1'b0;
                end else if (cand_ready) begin
                    take = 1'b1;
                    if (is_last) begin
                        state_n = S_DONE;
                        exh_n   = 1'b1;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Odometer step. The leading digit never wraps: the last candidate exits to DONE first.
    always_comb begin
        digits_n = digits;
        carry    = 1'b0;
        if (load) begin
            digits_n              = '0;
            digits_n[NUM_CHARS-1] = FROM_D;
        end else if (adv) begin
            carry = 1'b1;
            for (int i = 0; i < NUM_CHARS; i++) begin
                if (carry) begin
                    if (digits[i] == MAX_D && i != NUM_CHARS-1) begin
                        digits_n[i] = '0;
                    end else begin
                        digits_n[i] = digits[i] + 6'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CHARS; g++) begin : g_map
        pcg_char_map u_map (.idx(digits_n[g]), .ch(chars_n[g]));
    end

    // cand_data is registered from the next digits so it changes only with them
    // and can be cleared to zero on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            exhausted <= 1'b0;
            digits    <= '0;
            cand_data <= '0;
        end else begin
            state     <= state_n;
            exhausted <= exh_n;
            if (load || adv) begin
                digits    <= digits_n;
                cand_data <= chars_n;
            end
        end
    end

`ifdef CAND_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cand_count <= '0;
        else if (load) cand_count <= '0;
        else if (take) cand_count <= cand_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_password_candidate_gen.sv
module tb_password_candidate_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    string alpha = "abcdefghijklmnopqrstuvwxyz0123456789";

    // A: 2 chars, range 0..0
    logic a_start = 0, a_ready = 0, a_valid, a_done, a_exh;
    logic [15:0] a_data;
    // B: 1 char, range 35..35
    logic b_start = 0, b_ready = 0, b_valid, b_done, b_exh;
    logic [7:0] b_data;
    // C: defaults
    logic c_start = 0, c_ready = 0, c_abort = 0, c_valid, c_done, c_exh;
    logic [31:0] c_data;
    // D: 3 chars, range 0..3 (scaled-down full run)
    logic d_start = 0, d_ready = 0, d_valid, d_done, d_exh;
    logic [23:0] d_data;
`ifdef CAND_COUNT_EN
    logic [31:0] a_cnt, b_cnt, c_cnt, d_cnt;
`endif

    password_candidate_gen #(.NUM_CHARS(2), .FROM_IDX(0), .TO_IDX(0)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(1'b0), .cand_valid(a_valid),
        .cand_ready(a_ready), .cand_data(a_data), .done(a_done),
`ifdef CAND_COUNT_EN
        .cand_count(a_cnt),
`endif
        .exhausted(a_exh));

    password_candidate_gen #(.NUM_CHARS(1), .FROM_IDX(35), .TO_IDX(35)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(1'b0), .cand_valid(b_valid),
        .cand_ready(b_ready), .cand_data(b_data), .done(b_done),
`ifdef CAND_COUNT_EN
        .cand_count(b_cnt),
`endif
        .exhausted(b_exh));

    password_candidate_gen u_c (
        .clk(clk), .rst(rst), .start(c_start), .abort(c_abort), .cand_valid(c_valid),
        .cand_ready(c_ready), .cand_data(c_data), .done(c_done),
`ifdef CAND_COUNT_EN
        .cand_count(c_cnt),
`endif
        .exhausted(c_exh));

    password_candidate_gen #(.NUM_CHARS(3), .FROM_IDX(0), .TO_IDX(3)) u_d (
        .clk(clk), .rst(rst), .start(d_start), .abort(1'b0), .cand_valid(d_valid),
        .cand_ready(d_ready), .cand_data(d_data), .done(d_done),
`ifdef CAND_COUNT_EN
        .cand_count(d_cnt),
`endif
        .exhausted(d_exh));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        st, rdy, ab;     // inputs applied this cycle
        logic        ev, ed, ex;      // expected valid/done/exhausted before the edge
        logic        cd;              // check cand_data
        logic [31:0] data;
    } vec_t;
    vec_t tv[17];

    initial begin
        logic [23:0] d_last;
        tv[0]  = '{0,1,0, 1,0,0, 1,"aaaa"};
        tv[1]  = '{0,0,0, 1,0,0, 1,"aaab"};
        tv[2]  = '{0,0,0, 1,0,0, 1,"aaab"};
        tv[3]  = '{0,1,0, 1,0,0, 1,"aaab"};
        tv[4]  = '{0,1,0, 1,0,0, 1,"aaac"};
        tv[5]  = '{0,0,0, 1,0,0, 1,"aaad"};
        tv[6]  = '{0,0,0, 1,0,0, 1,"aaad"};
        tv[7]  = '{0,1,0, 1,0,0, 1,"aaad"};
        tv[8]  = '{0,1,0, 1,0,0, 1,"aaae"};
        tv[9]  = '{0,1,0, 1,0,0, 1,"aaaf"};
        tv[10] = '{0,1,1, 1,0,0, 1,"aaag"};   // abort beats accept
        tv[11] = '{0,1,0, 0,1,0, 0,32'h0};
        tv[12] = '{0,0,1, 0,1,0, 0,32'h0};    // abort in DONE ignored
        tv[13] = '{1,0,0, 0,1,0, 0,32'h0};    // restart
        tv[14] = '{1,1,0, 1,0,0, 1,"aaaa"};   // start in RUN ignored
        tv[15] = '{1,1,0, 1,0,0, 1,"aaab"};
        tv[16] = '{0,0,0, 1,0,0, 1,"aaac"};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_c_valid", c_valid, 0);
        chk("rst_c_done",  c_done,  0);
        chk("rst_c_exh",   c_exh,   0);
        chk("rst_c_data",  c_data,  0);
        chk("rst_a_data",  a_data,  0);
        chk("rst_d_valid", d_valid, 0);
        rst = 0;

        // A: 2 chars, single leading symbol, ready tied high
        @(negedge clk); a_ready = 1; a_start = 1;
        @(negedge clk); a_start = 0;
        chk("A_first", a_data, "aa");
        for (int k = 0; k < 36; k++) begin
            chk("A_valid", a_valid, 1);
            chk("A_data", a_data, {alpha[0], alpha[k]});
            @(negedge clk);
        end
        chk("A_done", a_done, 1);
        chk("A_exh", a_exh, 1);
        chk("A_valid_off", a_valid, 0);
`ifdef CAND_COUNT_EN
        chk("A_count", a_cnt, 36);
        @(negedge clk);
        chk("A_count_hold", a_cnt, 36);
`endif
        // restart clears exhausted and begins again at "aa"
        a_start = 1; @(negedge clk); a_start = 0; a_ready = 0;
        chk("A_re_exh", a_exh, 0);
        chk("A_re_data", a_data, "aa");
        chk("A_re_valid", a_valid, 1);

        // B: single-character range 35..35
        b_ready = 1; b_start = 1; @(negedge clk); b_start = 0;
        chk("B_valid", b_valid, 1);
        chk("B_data", b_data, 8'h39);
        @(negedge clk);
        chk("B_done", b_done, 1);
        chk("B_exh", b_exh, 1);
        chk("B_valid_off", b_valid, 0);

        // C: handshake stalls, abort, restart, start-in-RUN
        c_start = 1; @(negedge clk); c_start = 0;
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("C_valid[%0d]", i), c_valid, tv[i].ev);
            chk($sformatf("C_done[%0d]", i), c_done, tv[i].ed);
            chk($sformatf("C_exh[%0d]", i), c_exh, tv[i].ex);
            if (tv[i].cd) chk($sformatf("C_data[%0d]", i), c_data, tv[i].data);
`ifdef CAND_COUNT_EN
            if (i == 11) chk("C_count_abort", c_cnt, 6);
`endif
            c_start = tv[i].st; c_ready = tv[i].rdy; c_abort = tv[i].ab;
            @(negedge clk);
        end
        c_start = 0; c_ready = 0; c_abort = 0;
        // mid-RUN reset takes effect without a clock edge
        #2 rst = 1;
        #1;
        chk("C_rst_valid", c_valid, 0);
        chk("C_rst_done", c_done, 0);
        chk("C_rst_exh", c_exh, 0);
        chk("C_rst_data", c_data, 0);
        @(negedge clk); rst = 0;
        repeat (3) @(negedge clk);
        chk("C_idle_valid", c_valid, 0);
        chk("C_idle_done", c_done, 0);

        // D: full range, ready tied high; 4*36*36 = 5184 candidates, last "d99"
        d_ready = 1; d_start = 1; @(negedge clk); d_start = 0;
        d_last = '0;
        for (int k = 0; k < 5184; k++) begin
            chk("D_valid", d_valid, 1);
            chk("D_data", d_data, {alpha[k/1296], alpha[(k/36)%36], alpha[k%36]});
            d_last = d_data;
            @(negedge clk);
        end
        chk("D_last", d_last, "d99");
        chk("D_done", d_done, 1);
        chk("D_exh", d_exh, 1);
`ifdef CAND_COUNT_EN
        chk("D_count", d_cnt, 5184);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/password_candidate_gen.md
Name: password_candidate_gen

Overview:
- Producer side of the cracker datapath: enumerates every NUM_CHARS-character candidate whose leading character lies in [FROM_IDX, TO_IDX] of the 36-symbol alphabet.
- Streams candidates over a valid/ready handshake into one processing element's comparator.
- One instance per processing element; nine instances cover index ranges 0-3, 4-7, …, 32-35.
- Reports exhaustion or abort to the top-level controller.

Parameters:
- NUM_CHARS, 4, characters per candidate (1..8).
- FROM_IDX, 0, first alphabet index for the leading (leftmost) character.
- TO_IDX, 3, last alphabet index for the leading character (FROM_IDX <= TO_IDX <= 35).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high; clears all state.
- start  in  1  single-cycle pulse; begins enumeration from IDLE or DONE.
- abort  in  1  stop request (e.g. another PE's found); sampled every cycle.
- cand_valid  out  1  candidate on cand_data is valid.
- cand_ready  in  1  consumer accepts candidate this cycle.
- cand_data  out  8*NUM_CHARS  ASCII candidate; leftmost char in MSBs [8*NUM_CHARS-1 -: 8].
- done  out  1  level; high in DONE state.
- exhausted  out  1  level; high with done when the full range was consumed, low on abort.

Behaviour:
- Alphabet mapping, combinational per digit:
  - index 0-25 -> 'a'..'z' (8'h61 + i).
  - index 26-35 -> '0'..'9' (8'h30 + i - 26).
  - Index >35 is never produced.
- Digit counters: NUM_CHARS 6-bit registers, odometer order.
  - Rightmost digit increments fastest, wraps 35->0 and carries left.
  - Leading digit runs FROM_IDX..TO_IDX; all others run 0..35.
- States:
  - IDLE: cand_valid=0.
  - RUN: cand_valid=1.
  - DONE: cand_valid=0, done=1.
- Transitions:
  - IDLE/DONE + start -> RUN. Digits load to {FROM_IDX, 0, …, 0}; exhausted clears. First candidate is valid the cycle after start.
  - RUN + accept (cand_valid && cand_ready), not the last candidate -> digits advance; the next candidate is valid the following cycle. Throughput is 1 candidate/cycle under continuous ready.
  - RUN + accept of the last candidate {TO_IDX, 35, …, 35} -> DONE with exhausted=1 on the next cycle.
  - RUN + abort -> DONE with exhausted=0 on the next cycle, regardless of cand_ready. Abort has priority over accept in the same cycle; the digits do not advance.
  - start while in RUN is ignored.
  - abort in IDLE or DONE is ignored.
- Handshake rules:
  - cand_data is held stable while cand_valid && !cand_ready.
  - cand_valid never drops in RUN except on exit to DONE.
  - cand_data value is don't-care when cand_valid=0. It holds its last value; the bench must not check it.
- Total candidates = (TO_IDX-FROM_IDX+1) * 36^(NUM_CHARS-1). With defaults this is 4*46656 = 186624.
- Reset, including mid-RUN:
  - state=IDLE, cand_valid=0, done=0, exhausted=0.
  - All digits=0, cand_data=0.
  - Effect is immediate (asynchronous).

Optional Feature:
- Macro CAND_COUNT_EN.
- When defined:
  - Adds output cand_count (32 bits).
  - Cleared on reset and on start.
  - Increments on each accept.
  - Holds its value in DONE.
  - Lets the top level report candidates tried per PE.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- NUM_CHARS=2, FROM_IDX=TO_IDX=0, ready tied 1, start pulse -> first cand_data "aa" one cycle after start. Sequence runs "ab".."az","a0".."a9". Exactly 36 accepts. done=1 and exhausted=1 on the cycle after "a9" is accepted. CAND_COUNT_EN: cand_count=36.
- NUM_CHARS=1, FROM_IDX=TO_IDX=35 -> single candidate "9" (8'h39), then done=1, exhausted=1.
- Defaults, ready toggled 1,0,0,1 pattern -> cand_data is unchanged across ready-low cycles. No candidate is skipped or duplicated: the first five accepted are "aaaa","aaab","aaac","aaad","aaae".
- Defaults, abort asserted on the cycle "aaag" is presented with ready=1 -> "aaag" is not accepted. done=1 and exhausted=0 next cycle; cand_valid=0. A new start restarts at "aaaa".
- Defaults, start asserted again during RUN -> ignored; the sequence continues. Rst pulsed mid-RUN -> cand_valid, done and exhausted go 0 immediately; the block stays IDLE until the next start.
- Defaults, ready tied 1 -> done rises exactly 186624 accepts after the first; the last accepted value is "d999".
